ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/ex_muldiv.sv | 146 ++++++++++++++
 tb/tb_ex_muldiv.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding and FSM state types shared by the multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit, one bit per cycle on magnitudes, sign fix in FIN.
// Divide ops are only built with MULDIV_DIV_EN; otherwise they complete at once flagged illegal.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [4:0]          rdn_in,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WordSize-1:0] result,
  output logic [4:0]          rdn,
  output logic                illegal
);
  localparam int W = WordSize;
  localparam int CW = $clog2(W + 1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d, prod;
  logic [W-1:0] m_q, m_d, result_q, result_d, ma, mb, mul_res, res_fin;
  logic [4:0] rd_q, rd_d, rdn_q, rdn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, a_neg, b_neg, last, fin_ok;
  logic [W:0] sum;
  assign a_neg = a[W-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign b_neg = b[W-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign ma = a_neg ? -a : a;
  assign mb = b_neg ? -b : b;
  assign last = cnt_q == CW'(W - 1);
  assign fin_ok = (state_q == S_FIN) & ~flush;
  // acc holds {partial product, multiplier} while multiplying, {remainder, quotient} while dividing
  assign sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign prod = neg_q ? -acc_q : acc_q;
  assign mul_res = (op_q == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
`ifdef MULDIV_DIV_EN
  logic negr_q, negr_d, spec_q, spec_d, div0, ovf;
  logic [W:0] diff;
  logic [W-1:0] quo, rem;
  assign div0 = b == '0;
  assign ovf = ~op[0] & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
  assign diff = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, m_q};
  assign quo = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  assign res_fin = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
  assign illegal = 1'b0;
`else
  assign res_fin = op_q[2] ? '0 : mul_res;
  assign illegal = fin_ok & op_q[2];
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    m_d = m_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    op_d = op_q;
    rd_d = rd_q;
`ifdef MULDIV_DIV_EN
    negr_d = negr_q;
    spec_d = spec_q;
`endif
    unique case (state_q)
      S_IDLE: if (start && !flush) begin
        op_d = op_e'(op);
        rd_d = rdn_in;
        cnt_d = '0;
        m_d = ma;
        acc_d = {{W{1'b0}}, mb};
        neg_d = a_neg ^ b_neg;
        state_d = S_MUL;
        if (op[2]) begin
`ifdef MULDIV_DIV_EN
          // special cases preload the final quotient/remainder and skip iteration
          m_d = mb;
          acc_d = div0 ? {a, {W{1'b1}}} : {{W{1'b0}}, ovf ? a : ma};
          neg_d = ~(div0 | ovf) & (a_neg ^ b_neg);
          negr_d = ~(div0 | ovf) & a_neg;
          spec_d = div0 | ovf;
          state_d = S_DIV;
`else
          state_d = S_FIN;
`endif
        end
      end
      S_MUL: begin
        acc_d = {sum, acc_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        state_d = last ? S_FIN : S_MUL;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: if (spec_q) state_d = S_FIN;
      else begin
        acc_d = {diff[W] ? {acc_q[2*W-2:W], acc_q[W-1]} : diff[W-1:0], acc_q[W-2:0], ~diff[W]};
        cnt_d = cnt_q + CW'(1);
        state_d = last ? S_FIN : S_DIV;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end
  assign result_d = fin_ok ? res_fin : result_q;
  assign rdn_d = fin_ok ? rd_q : rdn_q;
  assign result = result_d;
  assign rdn = rdn_d;
  assign done = fin_ok;
  assign busy = (state_q == S_MUL) | (state_q == S_DIV);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      op_q <= OP_MUL;
      acc_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      rd_q <= '0;
      result_q <= '0;
      rdn_q <= '0;
`ifdef MULDIV_DIV_EN
      negr_q <= 1'b0;
      spec_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      rd_q <= rd_d;
      result_q <= result_d;
      rdn_q <= rdn_d;
`ifdef MULDIV_DIV_EN
      negr_q <= negr_d;
      spec_q <= spec_d;
`endif
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table, corner sequences and random ops against an arithmetic model.
module tb_ex_muldiv;
  localparam int W = 32;
  localparam logic [31:0] MinNeg = 32'h8000_0000;
`ifdef MULDIV_DIV_EN
  localparam bit DivOn = 1'b1;
`else
  localparam bit DivOn = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0] rdn_in = '0;
  logic busy, done, illegal;
  logic [W-1:0] result;
  logic [4:0] rdn;
  int tests = 0, fails = 0;

  ex_muldiv #(.WordSize(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .rdn_in(rdn_in),
    .flush(flush), .busy(busy), .done(done), .result(result), .rdn(rdn), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] o;
    logic [31:0] x, y, r;
    int lat;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] dv(input logic [31:0] r);
    return DivOn ? r : 32'h0;
  endfunction

  function automatic int dl(input int l);
    return DivOn ? l : 1;
  endfunction

  // full-width signed/unsigned arithmetic; only divide-by-zero needs explicit handling
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    if (o[2] && !DivOn) return '0;
    case (o)
      3'd0, 3'd1: r = sx * sy;
      3'd2: r = sx * uy;
      3'd3: r = ux * uy;
      3'd4: r = (y == 0) ? '1 : sx / sy;
      3'd5: r = (y == 0) ? '1 : ux / uy;
      3'd6: r = (y == 0) ? {32'b0, x} : sx % sy;
      default: r = (y == 0) ? {32'b0, x} : ux % uy;
    endcase
    return (o == 3'd1 || o == 3'd2 || o == 3'd3) ? r[63:32] : r[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return 33;
    if (!DivOn) return 1;
    return (y == 0 || (!o[0] && x == MinNeg && y == '1)) ? 2 : 33;
  endfunction

  task automatic run_check(input string n, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] er, input int el);
    int lat, bh;
    logic [31:0] res;
    logic [4:0] rd, r;
    logic ill;
    r = 5'($urandom);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rdn_in = r;
    @(posedge clk);
    #1 start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; rdn_in = 5'($urandom);
    lat = 0; bh = 0; res = '0; rd = '0; ill = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (done) begin lat = c; res = result; rd = rdn; ill = illegal; end
      if (busy) bh++;
    end
    check({n, " latency"}, lat, el);
    check({n, " result"}, res, er);
    check({n, " rdn"}, rd, r);
    check({n, " illegal"}, ill, o[2] && !DivOn);
    check({n, " busy cycles"}, bh, el - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, nd;
    logic [31:0] res, x, y;
    logic [4:0] rd;
    logic [2:0] o;
    vt[0]  = '{3'd0, 32'd7, 32'd6, 32'd42, 33};
    vt[1]  = '{3'd1, MinNeg, MinNeg, 32'h4000_0000, 33};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33};
    vt[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33};
    vt[5]  = '{3'd1, 32'd0, 32'd0, 32'd0, 33};
    vt[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFD), dl(33)};
    vt[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, dv(32'hFFFF_FFFF), dl(33)};
    vt[8]  = '{3'd5, 32'h1234, 32'd0, dv(32'hFFFF_FFFF), dl(2)};
    vt[9]  = '{3'd4, MinNeg, 32'hFFFF_FFFF, dv(MinNeg), dl(2)};
    vt[10] = '{3'd6, MinNeg, 32'hFFFF_FFFF, dv(32'd0), dl(2)};
    vt[11] = '{3'd7, 32'h1234, 32'd0, dv(32'h1234), dl(2)};
    vt[12] = '{3'd7, 32'd100, 32'd7, dv(32'd2), dl(33)};
    #1;
    check("reset outputs", {busy, done, illegal, result, rdn}, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 13; i++)
      run_check($sformatf("vec%0d", i), vt[i].o, vt[i].x, vt[i].y, vt[i].r, vt[i].lat);
    // start while busy must be ignored, with no queued second operation
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6; rdn_in = 5'd17;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; res = '0; rd = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 5) begin start = 1'b1; op = 3'd3; a = '1; b = '1; rdn_in = 5'd2; end
      if (c == 6) start = 1'b0;
      if (done) begin lat = c; res = result; rd = rdn; end
    end
    check("ignore-start latency", lat, 33);
    check("ignore-start result", res, 32'd42);
    check("ignore-start rdn", rd, 5'd17);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done || busy) nd++; end
    check("ignore-start no queued op", nd, 0);
    check("result held", result, 32'd42);
    // flush in cycle 10 of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; rdn_in = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush busy before", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy cycle 11", busy, 1'b0);
    nd = 0;
    repeat (40) begin if (done) nd++; @(negedge clk); end
    check("flush no done", nd, 0);
    check("flush result kept", result, 32'd42);
    check("flush rdn kept", rdn, 5'd17);
    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done || busy) nd++; end
    check("flush+start ignored", nd, 0);
    // asynchronous reset in cycle 5
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; rdn_in = 5'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("mid-op reset result", result, 32'd0);
    check("mid-op reset rdn", rdn, 5'd0);
    check("mid-op reset flags", {busy, done, illegal}, 3'b000);
    @(negedge clk);
    rstn = 1'b1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done || busy) nd++; end
    check("post-reset idle", nd, 0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin x = MinNeg; y = '1; end
      run_check($sformatf("rand op%0d %h %h", o, x, y), o, x, y, ref_res(o, x, y), exp_lat(o, x, y));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
